// File: rtl/imem_stream_loader.sv
// Fills instruction memory from a framed byte stream: 16-bit word count, big-endian payload
// words, then an XOR checksum. The CPU is held in reset until a verified program is loaded.
module imem_stream_loader #(
  parameter int INST_MEM_SIZE  = 1024,
  parameter int CNT_W          = 11,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  output logic             o_in_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [CNT_W-1:0] o_words_written
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_n_hi;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_words;
  logic [23:0]      r_word;
  logic [1:0]       r_bidx;
  logic [7:0]       r_csum;
  logic [TMO_W-1:0] r_tmo;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_busy;
  logic             w_accept;
  logic [15:0]      w_n_full;
  logic             w_last_byte;
  logic             w_last_word;
  logic             w_tmo_hit;
  logic             w_enter_hi;

  assign w_busy      = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CHECK);
  assign w_accept    = w_busy && i_in_valid;
  assign w_n_full    = {r_n_hi, i_in_data};
  assign w_last_byte = (r_bidx == 2'd3);
  assign w_last_word = ((r_words + CNT_W'(1)) == r_n);
  // An accepted byte in the expiry cycle takes priority over the timeout.
  assign w_tmo_hit   = w_busy && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_enter_hi  = (w_state_nx == S_CNT_HI) && (r_state != S_CNT_HI);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nx = S_CNT_HI;
      S_CNT_HI: if (w_accept) w_state_nx = S_CNT_LO;
      S_CNT_LO: if (w_accept) begin
        if (w_n_full > 16'(INST_MEM_SIZE)) w_state_nx = S_ERR;
        else if (w_n_full == 16'd0)        w_state_nx = S_CHECK;
        else                               w_state_nx = S_DATA;
      end
      S_DATA:   if (w_accept && w_last_byte && w_last_word) w_state_nx = S_CHECK;
      S_CHECK:  if (w_accept) w_state_nx = (i_in_data == r_csum) ? S_DONE : S_ERR;
      S_DONE:   if (i_start) w_state_nx = S_CNT_HI;
      S_ERR:    if (i_start) w_state_nx = S_CNT_HI;
      default:  w_state_nx = S_IDLE;
    endcase
    if (w_tmo_hit) w_state_nx = S_ERR;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_n_hi  <= '0;
      r_n     <= '0;
      r_words <= '0;
      r_word  <= '0;
      r_bidx  <= '0;
      r_csum  <= '0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_enter_hi) begin
        r_words <= '0;
        r_csum  <= '0;
        r_bidx  <= '0;
        r_tmo   <= '0;
      end else if (w_busy) begin
        r_tmo <= w_accept ? '0 : r_tmo + TMO_W'(1);
      end
      if (w_accept) begin
        case (r_state)
          S_CNT_HI: r_n_hi <= i_in_data;
          S_CNT_LO: r_n    <= CNT_W'(w_n_full);
          S_DATA: begin
            r_csum <= r_csum ^ i_in_data;
            r_word <= {r_word[15:0], i_in_data};
            r_bidx <= r_bidx + 2'd1;
            if (w_last_byte) begin
              r_we    <= 1'b1;
              r_addr  <= 32'({r_words, 2'b00});
              r_wdata <= {r_word, i_in_data};
              r_words <= r_words + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready      = w_busy;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == S_DONE);
  assign o_error         = (r_state == S_ERR);
  assign o_cpu_hold      = (r_state != S_DONE);
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_words_written = r_words;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized scoreboard bench for imem_stream_loader: expected writes are queued as bytes are
// accepted and a negedge monitor checks each mem_we pulse; session outcomes come from the frame rules.
module tb_imem_stream_loader;

  localparam int CNT_W = 11;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic             i_in_valid;
  logic [7:0]       i_in_data;
  logic             o_in_ready;
  logic             o_mem_we;
  logic [31:0]      o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic             o_cpu_hold;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [CNT_W-1:0] o_words_written;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;
  wr_t sb_q[$];
  bq_t sess;

  imem_stream_loader #(
    .INST_MEM_SIZE (1024),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_cpu_hold     (o_cpu_hold),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_words_written(o_words_written)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
  always @(negedge i_clk) begin
    if (o_mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h want=no write", o_mem_addr, o_mem_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", o_mem_addr, e.addr);
        chk("wr_data", o_mem_wdata, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  function automatic int rand_idle();
    return ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 3));
  endfunction

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_mem_we",   32'(o_mem_we), 32'd0);
    chk("rst_addr",     o_mem_addr, 32'd0);
    chk("rst_wdata",    o_mem_wdata, 32'd0);
    chk("rst_cpu_hold", 32'(o_cpu_hold), 32'd1);
    chk("rst_busy",     32'(o_busy), 32'd0);
    chk("rst_done",     32'(o_done), 32'd0);
    chk("rst_error",    32'(o_error), 32'd0);
    chk("rst_words",    32'(o_words_written), 32'd0);
  endtask

  task automatic pulse_start(input bit new_session);
    if (new_session) sess.delete();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  // Offer one byte after 'idle' quiet cycles and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b, input int idle, output bit ok);
    bit rdy;
    ok = 1'b0;
    repeat (idle) @(posedge i_clk);
    if (idle > 0) #1;
    i_in_valid = 1'b1;
    i_in_data  = b;
    for (int k = 0; k < 60 && !ok; k++) begin
      rdy = o_in_ready;
      @(posedge i_clk); #1;
      if (rdy) ok = 1'b1;
    end
    i_in_valid = 1'b0;
    i_in_data  = $urandom_range(0, 255);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got byte 0x%02h not accepted want accepted", b);
    end
  endtask

  // Payload byte: every 4th accepted byte of the session yields one expected big-endian write.
  task automatic send_payload(input logic [7:0] b, input int idle);
    bit ok;
    int k;
    wr_t e;
    send_byte(b, idle, ok);
    if (ok) begin
      sess.push_back(b);
      if (sess.size() % 4 == 0) begin
        k      = sess.size() / 4 - 1;
        e.addr = 32'(4 * k);
        e.data = {sess[4*k], sess[4*k+1], sess[4*k+2], sess[4*k+3]};
        e.cyc  = cyc;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] n, input bq_t pl, input logic [7:0] cs,
                           input bit mid_start);
    bit          ok;
    bit          size_err;
    bit          done_exp;
    logic [7:0]  x;
    x = 8'h00;
    foreach (pl[i]) x = x ^ pl[i];
    size_err = (n > 16'd1024);
    done_exp = !size_err && (cs == x);
    pulse_start(1'b1);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("hold_while_busy", 32'(o_cpu_hold), 32'd1);
    send_byte(n[15:8], rand_idle(), ok);
    send_byte(n[7:0], rand_idle(), ok);
    if (!size_err) begin
      foreach (pl[i]) begin
        send_payload(pl[i], rand_idle());
        if (mid_start && i == 1) pulse_start(1'b0);
      end
      send_byte(cs, rand_idle(), ok);
    end
    repeat (2) @(posedge i_clk); #1;
    chk("frame_done",  32'(o_done), 32'(done_exp));
    chk("frame_error", 32'(o_error), 32'(!done_exp));
    chk("frame_hold",  32'(o_cpu_hold), 32'(!done_exp));
    chk("frame_words", 32'(o_words_written), size_err ? 32'd0 : 32'(n));
    chk("frame_ready", 32'(o_in_ready), 32'd0);
  endtask

  initial begin
    bq_t  pl;
    bit   ok;
    int   n;
    logic [7:0] x;

    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    repeat (3) @(posedge i_clk); #1;
    check_reset_vals();
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Two-word program, good and corrupted checksum.
    pl = '{8'h02, 8'h11, 8'h40, 8'h20, 8'h01, 8'h13, 8'h48, 8'h21};
    x = 8'h02 ^ 8'h11 ^ 8'h40 ^ 8'h20 ^ 8'h01 ^ 8'h13 ^ 8'h48 ^ 8'h21;
    run_frame(16'd2, pl, x, 1'b0);
    run_frame(16'd2, pl, ~x, 1'b0);

    // Oversized count: no data accepted, stream ignored afterwards.
    pl.delete();
    run_frame(16'd1025, pl, 8'h00, 1'b0);
    repeat (5) begin
      i_in_valid = 1'b1;
      i_in_data  = $urandom_range(0, 255);
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
    chk("oversize_error_holds", 32'(o_error), 32'd1);
    chk("oversize_not_ready", 32'(o_in_ready), 32'd0);

    // Empty program.
    run_frame(16'd0, pl, 8'h00, 1'b0);
    run_frame(16'd0, pl, 8'h5A, 1'b0);

    // Timeout: stall after two payload bytes.
    pulse_start(1'b1);
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok);
    send_payload(8'hA1, 0);
    send_payload(8'hB2, 0);
    repeat (49) @(posedge i_clk); #1;
    chk("tmo_not_yet", 32'(o_error), 32'd0);
    @(posedge i_clk); #1;
    chk("tmo_error", 32'(o_error), 32'd1);
    chk("tmo_hold", 32'(o_cpu_hold), 32'd1);
    chk("tmo_words", 32'(o_words_written), 32'd0);

    // A byte accepted exactly in the expiry cycle keeps the session alive.
    pulse_start(1'b1);
    send_byte(8'h00, 0, ok);
    send_byte(8'h01, 0, ok);
    send_payload(8'hA1, 0);
    send_payload(8'hB2, 0);
    send_payload(8'hC3, 49);
    chk("tmo_edge_no_error", 32'(o_error), 32'd0);
    chk("tmo_edge_busy", 32'(o_busy), 32'd1);
    send_payload(8'hD4, 0);
    send_byte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4, 0, ok);
    @(posedge i_clk); #1;
    chk("tmo_edge_done", 32'(o_done), 32'd1);

    // Reset mid-word, then reload from address 0 with a start pulse mid-session.
    pulse_start(1'b1);
    send_byte(8'h00, 0, ok);
    send_byte(8'h03, 0, ok);
    for (int i = 0; i < 6; i++) send_payload(8'($urandom_range(0, 255)), rand_idle());
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check_reset_vals();
    i_rst = 1'b0;
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    x = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
    run_frame(16'd2, pl, x, 1'b1);

    // Random frames from mixed DONE/ERR starting states.
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(0, 6);
      pl.delete();
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        pl.push_back(8'($urandom_range(0, 255)));
        x = x ^ pl[i];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      run_frame(16'(n), pl, x, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge i_clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
